// File: rtl/rv32_multicycle_core_if.sv
// Instruction-fetch handshake between the core (master) and instruction memory (slave).
// Request side: valid/ready on the address; response side: a single valid qualifying inst_in.
// The core holds ifu_addr and ifu_req_valid stable until ifu_req_ready is seen.
interface rv32_multicycle_core_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] inst_in;

    modport master (
        output ifu_req_valid,
        output ifu_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  inst_in
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output inst_in
    );
endinterface

// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: REQ -> WAIT -> EXEC per instruction, halts on EBREAK/illegal.
// Latency: 3 cycles per instruction with zero-wait memory, plus request/response stalls.
// Backpressure: REQ holds address and valid until ready; WAIT idles until the response arrives.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h80000000,
    parameter int          NR_REG          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    rv32_multicycle_core_if.master        ifu,
    output logic [31:0]                   pc_out,
    output logic                          wb_valid,
    output logic [31:0]                   wb_pc,
    output logic [4:0]                    wb_rd,
    output logic [31:0]                   wb_data,
    output logic                          halt,
    output logic                          halt_illegal,
    output logic [31:0]                   halt_code
);
    localparam int          RW        = $clog2(NR_REG);
    localparam logic [31:0] REG_LIMIT = 32'(NR_REG);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rf [NR_REG];

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'd0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Shared ALU for OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [31:0] alu_op(input logic [2:0] fn, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (fn)
            3'd0:    r = alt ? (a - b) : (a + b);
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Register reads; x0 and out-of-range indices read as zero
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    always_comb begin
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        if (rs1 != 5'd0 && {27'd0, rs1} < REG_LIMIT) rs1_val = rf[rs1[RW-1:0]];
        if (rs2 != 5'd0 && {27'd0, rs2} < REG_LIMIT) rs2_val = rf[rs2[RW-1:0]];
    end

    // Decode and execute the latched instruction
    logic        illegal;
    logic        is_ebreak;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        uses_rd;
    logic        taken;
    logic        rd_we;
    logic [31:0] result;
    logic [31:0] next_pc;
    always_comb begin
        illegal   = 1'b0;
        is_ebreak = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        uses_rd   = 1'b0;
        taken     = 1'b0;
        result    = 32'd0;
        next_pc   = pc + 32'd4;
        case (opcode)
            7'b0110011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) illegal = 1'b1;
                result = alu_op(f3, f7[5], rs1_val, rs2_val);
            end
            7'b0010011: begin
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
                if (f3 == 3'd1 && f7 != 7'h00) illegal = 1'b1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
                result = alu_op(f3, (f3 == 3'd5) && ir[30], rs1_val, imm_i);
            end
            7'b0110111: begin
                uses_rd = 1'b1;
                result  = imm_u;
            end
            7'b0010111: begin
                uses_rd = 1'b1;
                result  = pc + imm_u;
            end
            7'b1101111: begin
                uses_rd = 1'b1;
                result  = pc + 32'd4;
                next_pc = pc + imm_j;
            end
            7'b1100111: begin
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
                if (f3 != 3'd0) illegal = 1'b1;
                result  = pc + 32'd4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                case (f3)
                    3'd0:    taken = (rs1_val == rs2_val);
                    3'd1:    taken = (rs1_val != rs2_val);
                    3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'd6:    taken = (rs1_val <  rs2_val);
                    3'd7:    taken = (rs1_val >= rs2_val);
                    default: illegal = 1'b1;
                endcase
                if (taken) next_pc = pc + imm_b;
            end
            7'b1110011: begin
                if (ir == 32'h00100073) is_ebreak = 1'b1;
                else                    illegal   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (uses_rs1 && {27'd0, rs1} >= REG_LIMIT) illegal = 1'b1;
        if (uses_rs2 && {27'd0, rs2} >= REG_LIMIT) illegal = 1'b1;
        if (uses_rd  && {27'd0, rd}  >= REG_LIMIT) illegal = 1'b1;
        rd_we = uses_rd && !illegal && (rd != 5'd0);
    end

    // Retire trace is live only during EXEC; an illegal instruction that halts does not retire
    logic retire;
    assign retire   = (state == S_EXEC) && !(illegal && HALT_ON_ILLEGAL);
    assign wb_valid = retire;
    assign wb_pc    = retire ? pc : 32'd0;
    assign wb_rd    = (retire && rd_we) ? rd : 5'd0;
    assign wb_data  = (retire && rd_we) ? result : 32'd0;

    assign ifu.ifu_req_valid = (state == S_REQ);
    assign ifu.ifu_addr      = pc;
    assign pc_out            = pc;

    // Fetch/execute sequencing, PC update and halt capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            ir           <= 32'd0;
            halt         <= 1'b0;
            halt_illegal <= 1'b0;
            halt_code    <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (ifu.ifu_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ifu.ifu_rsp_valid) begin
                        ir    <= ifu.inst_in;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (illegal && HALT_ON_ILLEGAL) begin
                        state        <= S_HALT;
                        halt         <= 1'b1;
                        halt_illegal <= 1'b1;
                        halt_code    <= rf[10];
                    end else if (is_ebreak) begin
                        state     <= S_HALT;
                        halt      <= 1'b1;
                        halt_code <= rf[10];
                    end else begin
                        pc    <= illegal ? (pc + 32'd4) : next_pc;
                        state <= S_REQ;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Register file write; no reset, x0 never written
    always_ff @(posedge clk) begin
        if (state == S_EXEC && rd_we) rf[rd[RW-1:0]] <= result;
    end
endmodule

// File: tb/tb_rv32_multicycle_core.sv
module tb_rv32_multicycle_core;
    localparam logic [31:0] RPC = 32'h80000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: default parameters, driven by the directed/random fetch sequencer
    logic        rst_a;
    logic [31:0] pc_out_a, wb_pc_a, wb_data_a, halt_code_a;
    logic [4:0]  wb_rd_a;
    logic        wb_valid_a, halt_a, halt_illegal_a;
    rv32_multicycle_core_if ifa();
    rv32_multicycle_core u_a (
        .clk(clk), .rst(rst_a), .ifu(ifa), .pc_out(pc_out_a),
        .wb_valid(wb_valid_a), .wb_pc(wb_pc_a), .wb_rd(wb_rd_a), .wb_data(wb_data_a),
        .halt(halt_a), .halt_illegal(halt_illegal_a), .halt_code(halt_code_a)
    );

    // DUT B: RV32E; DUT C: illegal instructions retire as NOPs
    logic        rst_bc;
    logic [31:0] pc_out_b, wb_pc_b, wb_data_b, halt_code_b;
    logic [4:0]  wb_rd_b;
    logic        wb_valid_b, halt_b, halt_illegal_b;
    rv32_multicycle_core_if ifb();
    rv32_multicycle_core #(.NR_REG(16)) u_b (
        .clk(clk), .rst(rst_bc), .ifu(ifb), .pc_out(pc_out_b),
        .wb_valid(wb_valid_b), .wb_pc(wb_pc_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b),
        .halt(halt_b), .halt_illegal(halt_illegal_b), .halt_code(halt_code_b)
    );

    logic [31:0] pc_out_c, wb_pc_c, wb_data_c, halt_code_c;
    logic [4:0]  wb_rd_c;
    logic        wb_valid_c, halt_c, halt_illegal_c;
    rv32_multicycle_core_if ifc();
    rv32_multicycle_core #(.HALT_ON_ILLEGAL(1'b0)) u_c (
        .clk(clk), .rst(rst_bc), .ifu(ifc), .pc_out(pc_out_c),
        .wb_valid(wb_valid_c), .wb_pc(wb_pc_c), .wb_rd(wb_rd_c), .wb_data(wb_data_c),
        .halt(halt_c), .halt_illegal(halt_illegal_c), .halt_code(halt_code_c)
    );

    typedef enum int {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, EBREAK
    } op_e;

    // Architectural reference state
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext12(input logic [31:0] r);
        return {{20{r[11]}}, r[11:0]};
    endfunction

    function automatic logic [31:0] br_word(input logic [2:0] f3, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    // Assembler: instruction description -> machine word
    function automatic logic [31:0] encode(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'd0;
        case (op)
            ADD:    w = {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            SUB:    w = {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            SLL:    w = {7'h00, rs2, rs1, 3'd1, rd, 7'h33};
            SLT:    w = {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
            SLTU:   w = {7'h00, rs2, rs1, 3'd3, rd, 7'h33};
            XOR:    w = {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
            SRL:    w = {7'h00, rs2, rs1, 3'd5, rd, 7'h33};
            SRA:    w = {7'h20, rs2, rs1, 3'd5, rd, 7'h33};
            OR:     w = {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            AND:    w = {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            ADDI:   w = {imm[11:0], rs1, 3'd0, rd, 7'h13};
            SLTI:   w = {imm[11:0], rs1, 3'd2, rd, 7'h13};
            SLTIU:  w = {imm[11:0], rs1, 3'd3, rd, 7'h13};
            XORI:   w = {imm[11:0], rs1, 3'd4, rd, 7'h13};
            ORI:    w = {imm[11:0], rs1, 3'd6, rd, 7'h13};
            ANDI:   w = {imm[11:0], rs1, 3'd7, rd, 7'h13};
            SLLI:   w = {7'h00, imm[4:0], rs1, 3'd1, rd, 7'h13};
            SRLI:   w = {7'h00, imm[4:0], rs1, 3'd5, rd, 7'h13};
            SRAI:   w = {7'h20, imm[4:0], rs1, 3'd5, rd, 7'h13};
            LUI:    w = {imm[19:0], rd, 7'h37};
            AUIPC:  w = {imm[19:0], rd, 7'h17};
            JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
            JALR:   w = {imm[11:0], rs1, 3'd0, rd, 7'h67};
            BEQ:    w = br_word(3'd0, rs1, rs2, imm);
            BNE:    w = br_word(3'd1, rs1, rs2, imm);
            BLT:    w = br_word(3'd4, rs1, rs2, imm);
            BGE:    w = br_word(3'd5, rs1, rs2, imm);
            BLTU:   w = br_word(3'd6, rs1, rs2, imm);
            BGEU:   w = br_word(3'd7, rs1, rs2, imm);
            default: w = 32'h00100073;
        endcase
        return w;
    endfunction

    // Reference semantics on the instruction description (not the encoding)
    task automatic model_step(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              output logic [4:0] e_rd, output logic [31:0] e_data,
                              output logic [31:0] e_npc, output bit e_halt);
        logic [31:0] a, b, res;
        bit wr, taken;
        a = (rs1 == 0) ? 32'd0 : m_reg[rs1];
        b = (rs2 == 0) ? 32'd0 : m_reg[rs2];
        res = 32'd0; wr = 1; taken = 0; e_halt = 0;
        e_npc = m_pc + 32'd4;
        case (op)
            ADD:   res = a + b;
            SUB:   res = a - b;
            SLL:   res = a << b[4:0];
            SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:  res = (a < b) ? 32'd1 : 32'd0;
            XOR:   res = a ^ b;
            SRL:   res = a >> b[4:0];
            SRA:   res = 32'($signed(a) >>> b[4:0]);
            OR:    res = a | b;
            AND:   res = a & b;
            ADDI:  res = a + imm;
            SLTI:  res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            SLTIU: res = (a < imm) ? 32'd1 : 32'd0;
            XORI:  res = a ^ imm;
            ORI:   res = a | imm;
            ANDI:  res = a & imm;
            SLLI:  res = a << imm[4:0];
            SRLI:  res = a >> imm[4:0];
            SRAI:  res = 32'($signed(a) >>> imm[4:0]);
            LUI:   res = imm << 12;
            AUIPC: res = m_pc + (imm << 12);
            JAL:   begin res = m_pc + 32'd4; e_npc = m_pc + imm; end
            JALR:  begin res = m_pc + 32'd4; e_npc = (a + imm) & ~32'd1; end
            BEQ:   begin wr = 0; taken = (a == b); end
            BNE:   begin wr = 0; taken = (a != b); end
            BLT:   begin wr = 0; taken = ($signed(a) < $signed(b)); end
            BGE:   begin wr = 0; taken = ($signed(a) >= $signed(b)); end
            BLTU:  begin wr = 0; taken = (a < b); end
            BGEU:  begin wr = 0; taken = (a >= b); end
            default: begin wr = 0; e_halt = 1; end
        endcase
        if (taken) e_npc = m_pc + imm;
        e_rd   = (wr && rd != 0) ? rd : 5'd0;
        e_data = (e_rd != 0) ? res : 32'd0;
    endtask

    task automatic wait_req(input string tag);
        int t;
        t = 0;
        while (ifa.ifu_req_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(tag, {31'd0, ifa.ifu_req_valid}, 32'd1);
    endtask

    // One full fetch/execute with the given memory stalls; checks against the model
    task automatic run_inst(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input int req_dly, input int rsp_dly, output logic [31:0] got);
        logic [31:0] inst, e_data, e_npc;
        logic [4:0]  e_rd;
        bit          e_halt;
        int          c0;
        inst = encode(op, rd, rs1, rs2, imm);
        wait_req("req_valid");
        c0 = cyc;
        check("fetch_addr", ifa.ifu_addr, m_pc);
        check("pc_out", pc_out_a, m_pc);
        for (int i = 0; i < req_dly; i++) begin
            @(negedge clk);
            check("addr_stable", ifa.ifu_addr, m_pc);
            check("req_held", {31'd0, ifa.ifu_req_valid}, 32'd1);
        end
        // handshake cycle carries a poison response that must not be latched
        ifa.ifu_req_ready = 1'b1;
        ifa.ifu_rsp_valid = 1'b1;
        ifa.inst_in       = 32'h00100073;
        @(negedge clk);
        ifa.ifu_req_ready = 1'b0;
        ifa.ifu_rsp_valid = 1'b0;
        check("wait_no_req", {31'd0, ifa.ifu_req_valid}, 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            check("no_early_wb", {31'd0, wb_valid_a}, 32'd0);
            @(negedge clk);
        end
        ifa.ifu_rsp_valid = 1'b1;
        ifa.inst_in       = inst;
        @(negedge clk);
        ifa.ifu_rsp_valid = 1'b0;
        ifa.inst_in       = $urandom;
        model_step(op, rd, rs1, rs2, imm, e_rd, e_data, e_npc, e_halt);
        check("latency", 32'(cyc - c0), 32'(2 + req_dly + rsp_dly));
        check("wb_valid", {31'd0, wb_valid_a}, 32'd1);
        check("wb_pc", wb_pc_a, m_pc);
        check("wb_rd", {27'd0, wb_rd_a}, {27'd0, e_rd});
        if (e_rd != 0) check("wb_data", wb_data_a, e_data);
        got = wb_data_a;
        if (e_rd != 0) m_reg[e_rd] = e_data;
        if (!e_halt) m_pc = e_npc;
        @(negedge clk);
        check("wb_single", {31'd0, wb_valid_a}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    logic [31:0] got, pc0, r;
    op_e         rop;
    int          nb, nc;
    logic [31:0] exp_pc_c;

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        ifa.ifu_req_ready = 1'b0; ifa.ifu_rsp_valid = 1'b0; ifa.inst_in = 32'd0;
        ifb.ifu_req_ready = 1'b1; ifb.ifu_rsp_valid = 1'b1; ifb.inst_in = encode(ADDI, 5'd20, 5'd0, 5'd0, 32'd1);
        ifc.ifu_req_ready = 1'b1; ifc.ifu_rsp_valid = 1'b1; ifc.inst_in = 32'hFFFFFFFF;
        rst_a = 1'b1; rst_bc = 1'b1;
        repeat (3) @(negedge clk);
        // reset state
        check("rst_addr", ifa.ifu_addr, RPC);
        check("rst_wb_valid", {31'd0, wb_valid_a}, 32'd0);
        check("rst_wb_pc", wb_pc_a, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd_a}, 32'd0);
        check("rst_halt", {31'd0, halt_a}, 32'd0);
        check("rst_halt_code", halt_code_a, 32'd0);
        rst_a = 1'b0;
        m_pc = RPC;

        // zero-wait first instruction, then stalled request and response
        run_inst(ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, got);
        check("addi5", got, 32'd5);
        run_inst(ADDI, 5'd2, 5'd0, 5'd0, 32'd7, 4, 3, got);

        // signed/unsigned compare and shift program
        run_inst(ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 0, got);
        run_inst(ADDI, 5'd2, 5'd0, 5'd0, 32'd1, 1, 0, got);
        run_inst(SLTU, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1, got);
        check("sltu_x3", got, 32'd0);
        run_inst(SLT, 5'd4, 5'd1, 5'd2, 32'd0, 0, 0, got);
        check("slt_x4", got, 32'd1);
        run_inst(SUB, 5'd5, 5'd2, 5'd1, 32'd0, 2, 2, got);
        check("sub_x5", got, 32'd2);
        run_inst(SRAI, 5'd6, 5'd1, 5'd0, 32'd4, 0, 0, got);
        check("srai_x6", got, 32'hFFFFFFFF);

        // full-range initial values for every register
        for (int k = 1; k < 32; k++) begin
            run_inst(LUI, 5'(k), 5'd0, 5'd0, 32'($urandom) & 32'h000FFFFF, 0, 0, got);
            r = $urandom;
            run_inst(ADDI, 5'(k), 5'(k), 5'd0, sext12(r), 0, 0, got);
        end

        // random instruction stream with random stalls
        for (int n = 0; n < 150; n++) begin
            rop = op_e'($urandom_range(0, 28));
            r = $urandom;
            case (rop)
                SLLI, SRLI, SRAI:            r = r & 32'd31;
                LUI, AUIPC:                  r = r & 32'h000FFFFF;
                JAL, BEQ, BNE, BLT, BGE, BLTU, BGEU: r = 32'($urandom_range(0, 63) * 4) - 32'd128;
                default:                     r = sext12(r);
            endcase
            run_inst(rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), r, $urandom_range(0, 2), $urandom_range(0, 2), got);
        end

        // branch/jump boundary cases
        pc0 = m_pc;
        run_inst(BNE, 5'd0, 5'd0, 5'd0, 32'd8, 0, 0, got);
        run_inst(BEQ, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 0, 0, got);
        wait_req("req_after_beq");
        check("beq_target", ifa.ifu_addr, pc0);
        pc0 = m_pc;
        run_inst(JALR, 5'd1, 5'd0, 5'd0, 32'h103, 0, 0, got);
        check("jalr_link", got, pc0 + 32'd4);
        wait_req("req_after_jalr");
        check("jalr_target", ifa.ifu_addr, 32'h00000102);
        // PC wrap from 0xFFFFFFFC
        run_inst(JALR, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 0, 0, got);
        run_inst(ADDI, 5'd7, 5'd0, 5'd0, 32'd3, 0, 0, got);
        wait_req("req_after_wrap");
        check("pc_wrap", ifa.ifu_addr, 32'd0);

        // EBREAK halt
        run_inst(ADDI, 5'd10, 5'd0, 5'd0, 32'd42, 0, 0, got);
        pc0 = m_pc;
        run_inst(EBREAK, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, got);
        check("halt", {31'd0, halt_a}, 32'd1);
        check("halt_code", halt_code_a, 32'd42);
        check("halt_illegal0", {31'd0, halt_illegal_a}, 32'd0);
        check("halt_pc", pc_out_a, pc0);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifa.ifu_req_valid || wb_valid_a) nb++;
        end
        check("halt_quiet", 32'(nb), 32'd0);

        // reset restarts fetch
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        m_pc = RPC;
        check("restart_addr", ifa.ifu_addr, RPC);
        check("restart_halt", {31'd0, halt_a}, 32'd0);
        check("restart_code", halt_code_a, 32'd0);

        // reset during WAIT, response arriving after reset is ignored
        ifa.ifu_req_ready = 1'b1;
        @(negedge clk);
        ifa.ifu_req_ready = 1'b0;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        ifa.ifu_rsp_valid = 1'b1;
        ifa.inst_in = encode(ADDI, 5'd10, 5'd0, 5'd0, 32'd99);
        @(negedge clk);
        ifa.ifu_rsp_valid = 1'b0;
        check("rstwait_req", {31'd0, ifa.ifu_req_valid}, 32'd1);
        check("rstwait_addr", ifa.ifu_addr, RPC);
        check("rstwait_wb", {31'd0, wb_valid_a}, 32'd0);
        run_inst(ADDI, 5'd11, 5'd0, 5'd0, 32'd17, 0, 0, got);

        // RV32E illegal register and NOP-on-illegal variants
        rst_bc = 1'b0;
        nb = 0; nc = 0;
        exp_pc_c = RPC;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wb_valid_b) nb++;
            if (wb_valid_c) begin
                nc++;
                check("nop_wb_rd", {27'd0, wb_rd_c}, 32'd0);
                check("nop_wb_pc", wb_pc_c, exp_pc_c);
                exp_pc_c = exp_pc_c + 32'd4;
            end
        end
        check("e_no_retire", 32'(nb), 32'd0);
        check("e_halt", {31'd0, halt_b}, 32'd1);
        check("e_halt_illegal", {31'd0, halt_illegal_b}, 32'd1);
        check("e_no_req", {31'd0, ifb.ifu_req_valid}, 32'd0);
        check("e_pc_frozen", pc_out_b, RPC);
        check("nop_count", 32'(nc), 32'd4);
        check("nop_no_halt", {31'd0, halt_c}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32_multicycle_core.md
Name: rv32_multicycle_core

Overview:
- Parametrised successor to the single-cycle RV32 top.
- Multi-cycle RV32I/RV32E integer core with a valid/ready instruction-fetch handshake, so instruction memory latency may vary.
- Executes ALU, LUI, AUIPC, JAL, JALR and branches.
- Exposes a one-cycle retire (writeback) trace port for the difftest bench, and halts on EBREAK or on an illegal instruction.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- NR_REG, 32, number of architectural registers; legal values are 32 (RV32I) or 16 (RV32E).
- HALT_ON_ILLEGAL, 1, 1 = an illegal instruction halts the core; 0 = it retires as a NOP.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ifu_req_valid  output  1  fetch request valid.
- ifu_req_ready  input  1  memory accepts the request.
- ifu_addr  output  32  fetch address; always equals pc_out.
- ifu_rsp_valid  input  1  instruction data valid.
- inst_in  input  32  instruction word; sampled only when ifu_rsp_valid is high.
- pc_out  output  32  current PC.
- wb_valid  output  1  one-cycle retire pulse.
- wb_pc  output  32  PC of the retiring instruction.
- wb_rd  output  5  destination register; 0 when there is no write.
- wb_data  output  32  value written to rd.
- halt  output  1  core has stopped.
- halt_illegal  output  1  halt was caused by an illegal instruction.
- halt_code  output  32  value of x10 (a0) at halt.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=REQ, pc=RESET_PC, instruction register=0.
  - wb_valid=0, wb_pc=0, wb_rd=0, wb_data=0.
  - halt=0, halt_illegal=0, halt_code=0.
  - Register file is not cleared. x0 always reads 0.
  - A reset during a pending fetch abandons it; a late ifu_rsp_valid is ignored because the FSM is not in WAIT.
- FSM states: REQ, WAIT, EXEC, HALT.
  - REQ: ifu_req_valid=1, ifu_addr=pc. If ifu_req_ready=1, go to WAIT. Otherwise stay, holding addr and valid stable.
  - WAIT: ifu_req_valid=0. If ifu_rsp_valid=1, latch inst_in and go to EXEC. A response cycle coinciding with the request handshake is not accepted; the earliest usable response is the cycle after acceptance.
  - EXEC (exactly 1 cycle): decode, read rs1/rs2, compute, write rd, update pc. wb_valid=1 with wb_pc/wb_rd/wb_data for this cycle only. Next state is REQ, or HALT.
  - HALT: terminal until reset. halt=1, no fetch requests, wb_valid=0, pc frozen at the halting instruction's PC.
- Minimum cost: 3 cycles per instruction (REQ, WAIT, EXEC) with zero-wait memory.
- Instruction support:
  - OP and OP-IMM: all RV32I funct3/funct7 variants.
    - SUB/SRA are selected by funct7[5] on OP; SRAI by inst[30] on OP-IMM.
    - Shift amount = low 5 bits of the operand.
    - SLT/SLTU produce a 32-bit result of 0 or 1.
  - LUI: imm<<12. AUIPC: pc+(imm<<12).
  - JAL/JALR: rd=pc+4. JALR target=(rs1+imm)&~1.
  - Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: taken → pc+imm, not taken → pc+4.
  - Arithmetic is mod 2^32 and wraps silently; a PC overflow past 32'hFFFFFFFC wraps to 0.
  - Instruction-address misalignment is not checked.
- Writes:
  - rd=0 means no write, and wb_rd=0.
  - Branches report wb_rd=0, wb_data=0.
- EBREAK (32'h00100073):
  - Retires with wb_valid=1, wb_rd=0, then enters HALT.
  - halt_code = x10 value read in that EXEC cycle; halt_illegal=0.
- Illegal instruction:
  - Triggers: unknown opcode, bad funct3/funct7 combination, or any rs1/rs2/rd index >= NR_REG.
  - HALT_ON_ILLEGAL=1: no register write, wb_valid=0, HALT, halt_illegal=1, halt_code=x10.
  - HALT_ON_ILLEGAL=0: retires as a NOP with pc+4, wb_valid=1, wb_rd=0.
- Same-register read and write in EXEC: reads return the old value (write happens at the clock edge).

Test Plan:
- Reset then zero-wait memory returning `addi x1,x0,5` (32'h00500093) → first REQ ifu_addr=32'h80000000; wb_valid pulses once at cycle 3 with wb_pc=32'h80000000, wb_rd=1, wb_data=5; next ifu_addr=32'h80000004.
- Fetch with ifu_req_ready held low 4 cycles and a response delayed 3 cycles → ifu_addr stays stable throughout; no wb_valid before the response; exactly one retire per instruction.
- Program `addi x1,x0,-1`; `addi x2,x0,1`; `sltu x3,x1,x2`; `slt x4,x1,x2`; `sub x5,x2,x1`; `srai x6,x1,4` → x3=0, x4=1, x5=2, x6=32'hFFFFFFFF.
- `bne x0,x0,8` (not taken), `beq x0,x0,-4` (taken), and `jalr x1,x0,0x103` → next PCs are pc+4 and pc-4 respectively; the jalr retires with wb_rd=1 and wb_data=pc+4, and the following ifu_addr=32'h00000102 (bit 0 cleared).
- `addi x10,x0,42` then EBREAK → halt=1, halt_code=42, halt_illegal=0; no further ifu_req_valid; rst then restarts fetch at RESET_PC.
- NR_REG=16: `addi x20,x0,1` → halt_illegal=1, wb_valid=0. HALT_ON_ILLEGAL=0 with 32'hFFFFFFFF → wb_valid=1, wb_rd=0, pc+4. Reset asserted during WAIT with a response arriving the next cycle → the response is ignored and ifu_addr=RESET_PC.
